// File: rtl/pong_match_controller_if.sv
// Signal bundle between the Pong match controller and its game/display environment.
// The slave modport is the controller's view; the master modport is the environment's view.
interface pong_match_controller_if #(
    parameter int COORD_W = 6,
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [COORD_W-1:0] p1_paddle_y;
    logic [COORD_W-1:0] p2_paddle_y;
    logic               ball_run;
    logic               ball_center;
    logic               serve_dir;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [1:0]         winner;
    logic               point_pulse;
    logic [2:0]         state_out;

    modport slave (
        input  frame_tick, start, ball_x, ball_y, p1_paddle_y, p2_paddle_y,
        output ball_run, ball_center, serve_dir, p1_score, p2_score, winner,
               point_pulse, state_out
    );

    modport master (
        output frame_tick, start, ball_x, ball_y, p1_paddle_y, p2_paddle_y,
        input  ball_run, ball_center, serve_dir, p1_score, p2_score, winner,
               point_pulse, state_out
    );
endinterface

// File: rtl/pong_match_controller.sv
// Match-level Pong controller: serve countdown, miss detection against both paddles,
// score keeping to a limit, winner latch and game-over hold.
module pong_match_controller #(
    parameter int COORD_W       = 6,
    parameter int GAME_WIDTH    = 40,
    parameter int PADDLE_HEIGHT = 6,
    parameter int SCORE_LIMIT   = 9,
    parameter int SCORE_W       = 4,
    parameter int SERVE_FRAMES  = 60,
    parameter int POINT_FRAMES  = 30
) (
    input  logic                    clock,
    input  logic                    reset_n,
    pong_match_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_RUNNING   = 3'd2,
        S_POINT     = 3'd3,
        S_GAME_OVER = 3'd4
    } state_e;

    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [COORD_W-1:0] P2_COL     = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W:0]   PAD_SPAN   = (COORD_W + 1)'(PADDLE_HEIGHT - 1);
    localparam logic [SCORE_W-1:0] LIMIT      = SCORE_W'(SCORE_LIMIT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               point_pulse_q, point_pulse_d;
    logic               ball_run_q, ball_center_q;
    logic               start_q;

    logic               start_edge;
    logic [COORD_W:0]   ball_y_w, p1_top_w, p2_top_w;
    logic               p1_miss, p2_miss;

    assign start_edge = bus.start & ~start_q;

    // Paddle bottom is computed one bit wider so a paddle near the last row cannot wrap.
    assign ball_y_w = {1'b0, bus.ball_y};
    assign p1_top_w = {1'b0, bus.p1_paddle_y};
    assign p2_top_w = {1'b0, bus.p2_paddle_y};

    assign p1_miss = bus.frame_tick && (bus.ball_x == '0) &&
                     ((ball_y_w < p1_top_w) || (ball_y_w > p1_top_w + PAD_SPAN));
    assign p2_miss = bus.frame_tick && (bus.ball_x == P2_COL) &&
                     ((ball_y_w < p2_top_w) || (ball_y_w > p2_top_w + PAD_SPAN));

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        p1_score_d    = p1_score_q;
        p2_score_d    = p2_score_q;
        winner_d      = winner_q;
        serve_dir_d   = serve_dir_q;
        point_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_SERVE;
                    cnt_d   = '0;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = S_RUNNING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RUNNING: begin
                // A point is served toward the player who just lost it.
                if (p1_miss) begin
                    p2_score_d    = p2_score_q + 1'b1;
                    serve_dir_d   = 1'b0;
                    point_pulse_d = 1'b1;
                    state_d       = S_POINT;
                    cnt_d         = '0;
                end else if (p2_miss) begin
                    p1_score_d    = p1_score_q + 1'b1;
                    serve_dir_d   = 1'b1;
                    point_pulse_d = 1'b1;
                    state_d       = S_POINT;
                    cnt_d         = '0;
                end
            end
            S_POINT: begin
                if (p1_score_q == LIMIT) begin
                    winner_d = 2'b01;
                    state_d  = S_GAME_OVER;
                end else if (p2_score_q == LIMIT) begin
                    winner_d = 2'b10;
                    state_d  = S_GAME_OVER;
                end else if (bus.frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        state_d = S_SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                if (start_edge) begin
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    winner_d    = 2'b00;
                    serve_dir_d = 1'b1;
                    state_d     = S_SERVE;
                    cnt_d       = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            p1_score_q    <= '0;
            p2_score_q    <= '0;
            winner_q      <= 2'b00;
            serve_dir_q   <= 1'b1;
            point_pulse_q <= 1'b0;
            ball_run_q    <= 1'b0;
            ball_center_q <= 1'b1;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            winner_q      <= winner_d;
            serve_dir_q   <= serve_dir_d;
            point_pulse_q <= point_pulse_d;
            ball_run_q    <= (state_d == S_RUNNING);
            ball_center_q <= (state_d != S_RUNNING);
            start_q       <= bus.start;
        end
    end

    assign bus.state_out   = state_q;
    assign bus.ball_run    = ball_run_q;
    assign bus.ball_center = ball_center_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.p1_score    = p1_score_q;
    assign bus.p2_score    = p2_score_q;
    assign bus.winner      = winner_q;
    assign bus.point_pulse = point_pulse_q;

endmodule
